sfm_addmul_arbiter: RTL and testbench

// - Schedules the single shared add/mul FMA lane array between the ADD requester and the MUL requester.
// - Drives the datapath's operation select and per-channel grants.
// - Tracks in-flight results per channel and caps them, so a stalled consumer cannot fill the FMA pipe
//   and block the other channel.
// - Sits beside the vector add/mul unit inside the softmax datapath. Integration:
//   - add/mul valid into the unit are ANDed with add_grant_o / mul_grant_o.
//   - operation_o drives the unit's operation select.

---
 rtl/sfm_addmul_arbiter_pkg.sv | 32 +++
 rtl/sfm_addmul_arbiter_cnt.sv | 43 ++++
 rtl/sfm_addmul_arbiter.sv | 125 ++++++++++++
 tb/tb_sfm_addmul_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfm_addmul_arbiter_pkg.sv
// Shared types for the softmax add/mul lane arbiter: scheduling mode, FSM state
// and the operation select driven into the vector add/mul unit.
`timescale 1ns/1ps
package sfm_addmul_arbiter_pkg;

    typedef enum logic [1:0] {
        RR        = 2'd0,
        ADD_FIRST = 2'd1,
        MUL_FIRST = 2'd2
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ADD = 2'd1,
        GNT_MUL = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } operation_t;

    // Operation implied by a grant state; IDLE keeps whatever was selected before.
    function automatic operation_t state_op(input arb_state_t s, input operation_t held);
        operation_t op;
        op = held;
        if (s == GNT_ADD) op = OP_ADD;
        if (s == GNT_MUL) op = OP_MUL;
        return op;
    endfunction

endpackage

// File: rtl/sfm_addmul_arbiter_cnt.sv
// Per-channel in-flight result counter: +1 on an accepted input, -1 on a drained
// output, saturating at both ends, with a synchronous clear.
`timescale 1ns/1ps
module sfm_outstanding_cnt #(
    parameter int unsigned MAX_VAL = 8,
    parameter int unsigned W       = $clog2(MAX_VAL + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o
);
    localparam logic [W-1:0] MAX_CNT = W'(MAX_VAL);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == MAX_CNT);

    // A drain with nothing in flight means the unit and arbiter disagree about occupancy.
    dec_at_zero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && !clear_i && (cnt_q == '0)));

endmodule

// File: rtl/sfm_addmul_arbiter.sv
// Schedules the shared add/mul FMA lanes between the ADD and MUL requesters and
// caps in-flight results per channel so one stalled consumer cannot block the other.
`timescale 1ns/1ps
module sfm_addmul_arbiter
    import sfm_addmul_arbiter_pkg::*;
#(
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  arb_mode_t        mode_i,
    input  logic             add_req_i,
    input  logic             mul_req_i,
    input  logic             in_ready_i,
    input  logic             add_out_fire_i,
    input  logic             mul_out_fire_i,
    output operation_t       operation_o,
    output logic             add_grant_o,
    output logic             mul_grant_o,
    output logic [CNT_W-1:0] add_cnt_o,
    output logic [CNT_W-1:0] mul_cnt_o,
    output logic             busy_o
);
    localparam int unsigned        BURST_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    arb_state_t         state_q, state_d, oth_state;
    logic [BURST_W-1:0] burst_q, burst_d;
    operation_t         op_q, op_d, last_q, last_d;
    logic add_full, mul_full, add_elig, mul_elig, add_fire, mul_fire;
    logic in_add, cur_req, cur_fire, cur_elig, oth_elig, oth_prio, rr_mode;

    sfm_outstanding_cnt #(.MAX_VAL(MAX_OUTSTANDING), .W(CNT_W)) u_add_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .inc_i(add_fire), .dec_i(add_out_fire_i),
        .cnt_o(add_cnt_o), .full_o(add_full)
    );

    sfm_outstanding_cnt #(.MAX_VAL(MAX_OUTSTANDING), .W(CNT_W)) u_mul_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .inc_i(mul_fire), .dec_i(mul_out_fire_i),
        .cnt_o(mul_cnt_o), .full_o(mul_full)
    );

    // last_q resets to MUL so the first round-robin decision after reset serves ADD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            burst_q <= '0;
            op_q    <= OP_ADD;
            last_q  <= OP_MUL;
        end else if (clear_i) begin
            state_q <= IDLE;
            burst_q <= '0;
            op_q    <= OP_ADD;
            last_q  <= OP_MUL;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            op_q    <= op_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        add_elig  = add_req_i && !add_full;
        mul_elig  = mul_req_i && !mul_full;
        rr_mode   = (mode_i != ADD_FIRST) && (mode_i != MUL_FIRST);
        in_add    = (state_q == GNT_ADD);
        cur_req   = in_add ? add_req_i : mul_req_i;
        cur_fire  = add_fire || mul_fire;
        cur_elig  = in_add ? add_elig : mul_elig;
        oth_elig  = in_add ? mul_elig : add_elig;
        oth_prio  = in_add ? (mode_i == MUL_FIRST) : (mode_i == ADD_FIRST);
        oth_state = in_add ? GNT_MUL : GNT_ADD;

        state_d = state_q;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (add_elig && mul_elig) begin
                        if (mode_i == ADD_FIRST)      state_d = GNT_ADD;
                        else if (mode_i == MUL_FIRST) state_d = GNT_MUL;
                        else state_d = (last_q == OP_ADD) ? GNT_MUL : GNT_ADD;
                    end else if (add_elig) begin
                        state_d = GNT_ADD;
                    end else if (mul_elig) begin
                        state_d = GNT_MUL;
                    end
                end
                GNT_ADD, GNT_MUL: begin
                    // A pending valid must see a stable operation select until it is taken.
                    if (cur_req && !in_ready_i)                                 state_d = state_q;
                    else if (cur_fire && rr_mode && (burst_q == BURST_LAST) && oth_elig)
                                                                                state_d = oth_state;
                    else if (oth_prio && oth_elig)                              state_d = oth_state;
                    else if (!cur_elig && oth_elig)                             state_d = oth_state;
                    else if (!cur_elig)                                         state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        burst_d = burst_q;
        if (state_d != state_q)                          burst_d = '0;
        else if (cur_fire && (burst_q != BURST_LAST))    burst_d = burst_q + 1'b1;

        op_d   = state_op(state_d, op_q);
        last_d = state_op(state_d, last_q);
    end

    always_comb begin
        add_grant_o = enable_i && (state_q == GNT_ADD) && !add_full;
        mul_grant_o = enable_i && (state_q == GNT_MUL) && !mul_full;
        add_fire    = add_grant_o && add_req_i && in_ready_i;
        mul_fire    = mul_grant_o && mul_req_i && in_ready_i;
        operation_o = op_q;
        busy_o      = (state_q != IDLE) || (add_cnt_o != '0) || (mul_cnt_o != '0);
    end

endmodule

// File: tb/tb_sfm_addmul_arbiter.sv
// Directed scenarios for the add/mul lane arbiter with an expected-grant queue
// compared once per cycle against the observed grants.
`timescale 1ns/1ps
module tb_sfm_addmul_arbiter;
    import sfm_addmul_arbiter_pkg::*;

    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [1:0]  CH_NONE = 2'b00;
    localparam logic [1:0]  CH_ADD  = 2'b01;
    localparam logic [1:0]  CH_MUL  = 2'b10;

    logic             clk = 1'b0;
    logic             rst_n, clear, enable, add_req, mul_req, in_ready, add_of, mul_of;
    arb_mode_t        mode;
    operation_t       operation;
    logic             add_gnt, mul_gnt, busy;
    logic [CNT_W-1:0] add_cnt, mul_cnt;

    int checks = 0;
    int passed = 0;
    logic [1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    sfm_addmul_arbiter #(.BURST_LEN(4), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .mode_i(mode),
        .add_req_i(add_req), .mul_req_i(mul_req), .in_ready_i(in_ready),
        .add_out_fire_i(add_of), .mul_out_fire_i(mul_of),
        .operation_o(operation), .add_grant_o(add_gnt), .mul_grant_o(mul_gnt),
        .add_cnt_o(add_cnt), .mul_cnt_o(mul_cnt), .busy_o(busy)
    );

    // driver: idle inputs, reset, release at a falling edge (cycle 0)
    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; mode = RR;
        add_req = 1'b0; mul_req = 1'b0; in_ready = 1'b0; add_of = 1'b0; mul_of = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; mode = RR;
        add_req = 1'b1; mul_req = 1'b1; in_ready = 1'b1; add_of = 1'b0; mul_of = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({mul_gnt, add_gnt} !== CH_NONE) $display("FAIL reset_grants: got %b exp %b", {mul_gnt, add_gnt}, CH_NONE); else passed++;
        checks++; if (operation !== OP_ADD) $display("FAIL reset_op: got %b exp %b", operation, OP_ADD); else passed++;
        checks++; if (add_cnt !== '0) $display("FAIL reset_add_cnt: got %0d exp 0", add_cnt); else passed++;
        checks++; if (mul_cnt !== '0) $display("FAIL reset_mul_cnt: got %0d exp 0", mul_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
    endtask

    task automatic test_single_add();
        do_reset();
        add_req = 1'b1; in_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if ({mul_gnt, add_gnt} !== CH_ADD) $display("FAIL single_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, CH_ADD); else passed++;
            checks++; if (operation !== OP_ADD) $display("FAIL single_op c%0d: got %b exp %b", k, operation, OP_ADD); else passed++;
            checks++; if (add_cnt !== CNT_W'(k - 1)) $display("FAIL single_cnt c%0d: got %0d exp %0d", k, add_cnt, k - 1); else passed++;
        end
    endtask

    task automatic test_rr_burst();
        logic [1:0] exp_ch, prev;
        do_reset();
        add_req = 1'b1; mul_req = 1'b1; in_ready = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(((i / 4) % 2 == 0) ? CH_ADD : CH_MUL);
        prev = CH_NONE;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ch = exp_q.pop_front();
            checks++; if ({mul_gnt, add_gnt} !== exp_ch) $display("FAIL rr_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, exp_ch); else passed++;
            checks++; if (add_cnt !== CNT_W'(prev == CH_ADD)) $display("FAIL rr_add_cnt c%0d: got %0d exp %0d", k, add_cnt, prev == CH_ADD); else passed++;
            checks++; if (mul_cnt !== CNT_W'(prev == CH_MUL)) $display("FAIL rr_mul_cnt c%0d: got %0d exp %0d", k, mul_cnt, prev == CH_MUL); else passed++;
            add_of = (prev == CH_ADD);
            mul_of = (prev == CH_MUL);
            prev = exp_ch;
        end
    endtask

    task automatic test_stall();
        logic [1:0] exp_ch;
        operation_t exp_op;
        do_reset();
        mul_req = 1'b1; in_ready = 1'b0;
        for (int i = 1; i <= 9; i++) exp_q.push_back(CH_MUL);
        exp_q.push_back(CH_ADD);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_ch = exp_q.pop_front();
            exp_op = (exp_ch == CH_MUL) ? OP_MUL : OP_ADD;
            checks++; if ({mul_gnt, add_gnt} !== exp_ch) $display("FAIL stall_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, exp_ch); else passed++;
            checks++; if (operation !== exp_op) $display("FAIL stall_op c%0d: got %b exp %b", k, operation, exp_op); else passed++;
            checks++; if (mul_cnt !== CNT_W'((k <= 6) ? 0 : k - 6)) $display("FAIL stall_cnt c%0d: got %0d exp %0d", k, mul_cnt, (k <= 6) ? 0 : k - 6); else passed++;
            if (k == 1) add_req = 1'b1;
            if (k == 6) in_ready = 1'b1;
        end
    endtask

    task automatic test_outstanding_cap();
        logic [1:0] exp_ch;
        int exp_add, exp_mul;
        do_reset();
        add_req = 1'b1; in_ready = 1'b1;
        for (int i = 1; i <= 8; i++) exp_q.push_back(CH_ADD);
        exp_q.push_back(CH_NONE);
        for (int i = 10; i <= 16; i++) exp_q.push_back(CH_MUL);
        exp_q.push_back(CH_ADD);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_ch  = exp_q.pop_front();
            exp_add = (k <= 9) ? k - 1 : ((k <= 15) ? 8 : 7);
            exp_mul = (k <= 10) ? 0 : 1;
            checks++; if ({mul_gnt, add_gnt} !== exp_ch) $display("FAIL cap_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, exp_ch); else passed++;
            checks++; if (add_cnt !== CNT_W'(exp_add)) $display("FAIL cap_add_cnt c%0d: got %0d exp %0d", k, add_cnt, exp_add); else passed++;
            checks++; if (mul_cnt !== CNT_W'(exp_mul)) $display("FAIL cap_mul_cnt c%0d: got %0d exp %0d", k, mul_cnt, exp_mul); else passed++;
            if (k == 9) mul_req = 1'b1;
            mul_of = (k >= 11);
            add_of = (k == 15);
        end
    endtask

    task automatic test_add_first();
        logic [1:0] exp_ch;
        do_reset();
        mode = ADD_FIRST; add_req = 1'b1; mul_req = 1'b1; in_ready = 1'b1;
        for (int i = 1; i <= 6; i++) exp_q.push_back(CH_ADD);
        exp_q.push_back(CH_MUL);
        exp_q.push_back(CH_ADD);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_ch = exp_q.pop_front();
            checks++; if ({mul_gnt, add_gnt} !== exp_ch) $display("FAIL prio_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, exp_ch); else passed++;
            checks++; if (add_cnt !== CNT_W'(k >= 2 && k <= 6)) $display("FAIL prio_add_cnt c%0d: got %0d exp %0d", k, add_cnt, k >= 2 && k <= 6); else passed++;
            checks++; if (mul_cnt !== CNT_W'(k == 8)) $display("FAIL prio_mul_cnt c%0d: got %0d exp %0d", k, mul_cnt, k == 8); else passed++;
            add_of = (k >= 2 && k <= 6);
            mul_of = (k == 8);
            if (k == 6) add_req = 1'b0;
            if (k == 7) add_req = 1'b1;
        end
    endtask

    task automatic test_enable();
        do_reset();
        add_req = 1'b1; in_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (add_cnt !== CNT_W'(2)) $display("FAIL en_pre_cnt: got %0d exp 2", add_cnt); else passed++;
        enable = 1'b0; add_of = 1'b1;
        #1;
        checks++; if (add_gnt !== 1'b0) $display("FAIL en_grant_drop: got %b exp 0", add_gnt); else passed++;
        @(negedge clk);
        checks++; if (add_cnt !== CNT_W'(1)) $display("FAIL en_drain_cnt: got %0d exp 1", add_cnt); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL en_busy: got %b exp 1", busy); else passed++;
        enable = 1'b1; add_of = 1'b0;
        #1;
        checks++; if (add_gnt !== 1'b1) $display("FAIL en_resume: got %b exp 1", add_gnt); else passed++;
        @(negedge clk);
        checks++; if (add_cnt !== CNT_W'(2)) $display("FAIL en_post_cnt: got %0d exp 2", add_cnt); else passed++;
    endtask

    task automatic test_clear();
        logic [1:0] exp_ch;
        do_reset();
        add_req = 1'b1; in_ready = 1'b1;
        for (int i = 1; i <= 4; i++) exp_q.push_back(CH_ADD);
        for (int i = 5; i <= 10; i++) exp_q.push_back(CH_MUL);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_ch = exp_q.pop_front();
            checks++; if ({mul_gnt, add_gnt} !== exp_ch) $display("FAIL clr_grant c%0d: got %b exp %b", k, {mul_gnt, add_gnt}, exp_ch); else passed++;
            if (k == 4) begin
                add_req = 1'b0;
                mul_req = 1'b1;
            end
        end
        checks++; if (add_cnt !== CNT_W'(3) || mul_cnt !== CNT_W'(5)) $display("FAIL clr_pre_cnts: got %0d/%0d exp 3/5", add_cnt, mul_cnt); else passed++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if ({mul_gnt, add_gnt} !== CH_NONE) $display("FAIL clr_grants: got %b exp %b", {mul_gnt, add_gnt}, CH_NONE); else passed++;
        checks++; if (add_cnt !== '0 || mul_cnt !== '0) $display("FAIL clr_cnts: got %0d/%0d exp 0/0", add_cnt, mul_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b exp 0", busy); else passed++;
        checks++; if (operation !== OP_ADD) $display("FAIL clr_op: got %b exp %b", operation, OP_ADD); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        mul_req = 1'b1; in_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mul_gnt !== 1'b1 || mul_cnt !== CNT_W'(2)) $display("FAIL arst_pre: got gnt %b cnt %0d exp gnt 1 cnt 2", mul_gnt, mul_cnt); else passed++;
        checks++; if (operation !== OP_MUL) $display("FAIL arst_pre_op: got %b exp %b", operation, OP_MUL); else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mul_gnt, add_gnt} !== CH_NONE) $display("FAIL arst_grants: got %b exp %b", {mul_gnt, add_gnt}, CH_NONE); else passed++;
        checks++; if (mul_cnt !== '0) $display("FAIL arst_cnt: got %0d exp 0", mul_cnt); else passed++;
        checks++; if (operation !== OP_ADD) $display("FAIL arst_op: got %b exp %b", operation, OP_ADD); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b exp 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_rr_burst();
        test_stall();
        test_outstanding_cap();
        test_add_first();
        test_enable();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
